// File: rtl/rvh_l1d_pkg.sv
// Shared types for the L1D miss/victim controller.
// One state per step of the per-miss sequence, from accept to respond.
package rvh_l1d_pkg;

  typedef enum logic [3:0] {
    IDLE,
    META,
    SEL,
    WB_REQ,
    WB_WAIT,
    RF_REQ,
    RF_WAIT,
    WRITE,
    RESP
  } miss_state_e;

endpackage

// File: rtl/rvh_l1d_first_zero_sel.sv
// Priority encoder: index of the lowest-index zero bit, plus a found flag.
// Purely combinational, zero latency, no backpressure.
module rvh_l1d_first_zero_sel #(
  parameter int width = 4,
  parameter int idx_w = $clog2(width)
) (
  input  logic [width-1:0] vec,
  output logic [idx_w-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest zero is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        idx   = i[idx_w-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvh_l1d_miss_victim_ctrl.sv
// Per-miss replacement controller: meta read, victim pick, writeback, refill, install, respond.
// Minimum 6 cycles from accept to response; next accept one cycle after the response.
// Accepts only in IDLE; holds wb/refill requests stable until their ready, waits on done pulses.
module rvh_l1d_miss_victim_ctrl
  import rvh_l1d_pkg::*;
#(
  parameter int entry_num   = 32,
  parameter int entry_idx   = $clog2(entry_num),
  parameter int way_num     = 4,
  parameter int way_num_idx = $clog2(way_num),
  parameter int tag_w       = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req_vld,
  output logic                   miss_req_rdy,
  input  logic [entry_idx-1:0]   miss_req_set,
  input  logic [tag_w-1:0]       miss_req_tag,
  output logic                   meta_rd_en,
  output logic [entry_idx-1:0]   meta_rd_set,
  input  logic [way_num-1:0]     meta_rd_vld_vec,
  input  logic [way_num-1:0]     meta_rd_dirty_vec,
  output logic                   plru_rd_en,
  output logic [entry_idx-1:0]   plru_rd_set,
  input  logic [way_num_idx-1:0] plru_rd_way,
  output logic                   wb_req_vld,
  input  logic                   wb_req_rdy,
  output logic [entry_idx-1:0]   wb_req_set,
  output logic [way_num_idx-1:0] wb_req_way,
  input  logic                   wb_done,
  output logic                   refill_req_vld,
  input  logic                   refill_req_rdy,
  output logic [entry_idx-1:0]   refill_req_set,
  output logic [tag_w-1:0]       refill_req_tag,
  input  logic                   refill_done,
  output logic                   line_wr_en,
  output logic [entry_idx-1:0]   line_wr_set,
  output logic [way_num_idx-1:0] line_wr_way,
  output logic [tag_w-1:0]       line_wr_tag,
  output logic                   miss_resp_vld,
  output logic [way_num_idx-1:0] miss_resp_way
);

  miss_state_e            state_q;
  logic [entry_idx-1:0]   set_q;
  logic [tag_w-1:0]       tag_q;
  logic [way_num_idx-1:0] way_q;

  logic [way_num_idx-1:0] free_way;
  logic                   free_found;
  logic [way_num_idx-1:0] sel_way;
  logic                   sel_dirty;

  rvh_l1d_first_zero_sel #(
    .width (way_num),
    .idx_w (way_num_idx)
  ) u_free_sel (
    .vec   (meta_rd_vld_vec),
    .idx   (free_way),
    .found (free_found)
  );

  // An invalid victim can never be dirty; only a PLRU pick needs its dirty bit.
  assign sel_way   = free_found ? free_way : plru_rd_way;
  assign sel_dirty = !free_found && meta_rd_dirty_vec[plru_rd_way];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req_vld) begin
            set_q   <= miss_req_set;
            tag_q   <= miss_req_tag;
            state_q <= META;
          end
        end
        META:    state_q <= SEL;
        SEL: begin
          way_q   <= sel_way;
          state_q <= sel_dirty ? WB_REQ : RF_REQ;
        end
        WB_REQ:  if (wb_req_rdy)     state_q <= WB_WAIT;
        WB_WAIT: if (wb_done)        state_q <= RF_REQ;
        RF_REQ:  if (refill_req_rdy) state_q <= RF_WAIT;
        RF_WAIT: if (refill_done)    state_q <= WRITE;
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_req_rdy   = (state_q == IDLE);
  assign meta_rd_en     = (state_q == META);
  assign meta_rd_set    = set_q;
  // The PLRU read advances replacement state, so it fires only when every way is valid.
  assign plru_rd_en     = (state_q == SEL) && !free_found;
  assign plru_rd_set    = set_q;
  assign wb_req_vld     = (state_q == WB_REQ);
  assign wb_req_set     = set_q;
  assign wb_req_way     = way_q;
  assign refill_req_vld = (state_q == RF_REQ);
  assign refill_req_set = set_q;
  assign refill_req_tag = tag_q;
  assign line_wr_en     = (state_q == WRITE);
  assign line_wr_set    = set_q;
  assign line_wr_way    = way_q;
  assign line_wr_tag    = tag_q;
  assign miss_resp_vld  = (state_q == RESP);
  assign miss_resp_way  = way_q;

endmodule

// File: tb/tb_rvh_l1d_miss_victim_ctrl.sv
// Randomised bench for the miss/victim controller with a behavioural reference model.
module tb_rvh_l1d_miss_victim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req_vld, miss_req_rdy;
  logic [4:0]  miss_req_set;
  logic [19:0] miss_req_tag;
  logic        meta_rd_en;
  logic [4:0]  meta_rd_set;
  logic [3:0]  meta_rd_vld_vec, meta_rd_dirty_vec;
  logic        plru_rd_en;
  logic [4:0]  plru_rd_set;
  logic [1:0]  plru_rd_way;
  logic        wb_req_vld, wb_req_rdy;
  logic [4:0]  wb_req_set;
  logic [1:0]  wb_req_way;
  logic        wb_done;
  logic        refill_req_vld, refill_req_rdy;
  logic [4:0]  refill_req_set;
  logic [19:0] refill_req_tag;
  logic        refill_done;
  logic        line_wr_en;
  logic [4:0]  line_wr_set;
  logic [1:0]  line_wr_way;
  logic [19:0] line_wr_tag;
  logic        miss_resp_vld;
  logic [1:0]  miss_resp_way;

  always #5 clk = ~clk;

  rvh_l1d_miss_victim_ctrl dut (
    .clk (clk), .rst (rst),
    .miss_req_vld (miss_req_vld), .miss_req_rdy (miss_req_rdy),
    .miss_req_set (miss_req_set), .miss_req_tag (miss_req_tag),
    .meta_rd_en (meta_rd_en), .meta_rd_set (meta_rd_set),
    .meta_rd_vld_vec (meta_rd_vld_vec), .meta_rd_dirty_vec (meta_rd_dirty_vec),
    .plru_rd_en (plru_rd_en), .plru_rd_set (plru_rd_set), .plru_rd_way (plru_rd_way),
    .wb_req_vld (wb_req_vld), .wb_req_rdy (wb_req_rdy),
    .wb_req_set (wb_req_set), .wb_req_way (wb_req_way), .wb_done (wb_done),
    .refill_req_vld (refill_req_vld), .refill_req_rdy (refill_req_rdy),
    .refill_req_set (refill_req_set), .refill_req_tag (refill_req_tag),
    .refill_done (refill_done),
    .line_wr_en (line_wr_en), .line_wr_set (line_wr_set),
    .line_wr_way (line_wr_way), .line_wr_tag (line_wr_tag),
    .miss_resp_vld (miss_resp_vld), .miss_resp_way (miss_resp_way)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observations gathered by run_miss for one miss.
  int          o_rdy_hi, o_meta_cnt, o_plru_cnt, o_wb_hs, o_wb_vc, o_rf_hs;
  int          o_wr_cnt, o_wr_k, o_resp_cnt, o_resp_k;
  logic [4:0]  o_meta_set, o_plru_set, o_wb_set, o_rf_set, o_wr_set;
  logic [1:0]  o_wb_way, o_wr_way, o_resp_way;
  logic [19:0] o_rf_tag, o_wr_tag;
  bit          o_wb_unstable, o_rf_early, o_rdy_after_rst, o_start_rdy;

  // Reference model: lowest invalid way, else the PLRU way.
  function automatic logic [1:0] model_way(input logic [3:0] vv, input logic [1:0] pw);
    logic [1:0] w;
    w = pw;
    for (int i = 3; i >= 0; i--) if (!vv[i]) w = i[1:0];
    return w;
  endfunction

  function automatic bit model_dirty(input logic [3:0] vv, input logic [3:0] dv,
                                     input logic [1:0] pw);
    return (vv == 4'hF) && dv[pw];
  endfunction

  // Cycles from accept to response under the responder delays used by run_miss.
  function automatic int model_resp_k(input bit dirty, input int wd, input int wdd,
                                      input int rd, input int rdd);
    return 5 + rd + rdd + (dirty ? (1 + wd + wdd) : 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    miss_req_vld = 1'b0; wb_req_rdy = 1'b0; refill_req_rdy = 1'b0;
    wb_done = 1'b0; refill_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one miss and play the memory side; samples at negedge, drives for the next posedge.
  task automatic run_miss(input logic [4:0] s, input logic [19:0] t,
                          input logic [3:0] vv, input logic [3:0] dv, input logic [1:0] pw,
                          input int wd, input int wdd, input int rd, input int rdd,
                          input bit early_wbdone, input int rst_at, input bit hold_vld,
                          input int budget);
    int wb_hs_k, rf_hs_k, rf_vc;
    bit wbdone_given, stop;
    o_rdy_hi = 0; o_meta_cnt = 0; o_plru_cnt = 0; o_wb_hs = 0; o_wb_vc = 0; o_rf_hs = 0;
    o_wr_cnt = 0; o_wr_k = -1; o_resp_cnt = 0; o_resp_k = -1;
    o_meta_set = '0; o_plru_set = '0; o_wb_set = '0; o_rf_set = '0; o_wr_set = '0;
    o_wb_way = '0; o_wr_way = '0; o_resp_way = '0; o_rf_tag = '0; o_wr_tag = '0;
    o_wb_unstable = 0; o_rf_early = 0; o_rdy_after_rst = 0;
    wb_hs_k = -1000; rf_hs_k = -1000; rf_vc = 0; wbdone_given = 0; stop = 0;
    @(negedge clk);
    o_start_rdy = miss_req_rdy;
    miss_req_vld = 1'b1; miss_req_set = s; miss_req_tag = t;
    meta_rd_vld_vec = vv; meta_rd_dirty_vec = dv; plru_rd_way = pw;
    wb_req_rdy = 1'b0; refill_req_rdy = 1'b0; wb_done = 1'b0; refill_done = 1'b0;
    for (int k = 1; k <= budget && !stop; k++) begin
      @(negedge clk);
      if (!hold_vld) miss_req_vld = 1'b0;
      wb_done = 1'b0; refill_done = 1'b0; wb_req_rdy = 1'b0; refill_req_rdy = 1'b0;
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        rst = 1'b0;
        o_rdy_after_rst = miss_req_rdy;
        refill_done = 1'b1;
      end
      if (miss_req_rdy && !(rst_at > 0 && k > rst_at)) o_rdy_hi++;
      if (meta_rd_en) begin o_meta_cnt++; o_meta_set = meta_rd_set; end
      if (plru_rd_en) begin o_plru_cnt++; o_plru_set = plru_rd_set; end
      if (refill_req_vld) begin
        if (o_wb_hs > 0 && !wbdone_given) o_rf_early = 1;
        o_rf_set = refill_req_set; o_rf_tag = refill_req_tag; rf_vc++;
        if (rf_vc > rd) begin refill_req_rdy = 1'b1; o_rf_hs++; rf_hs_k = k; end
      end
      if (o_rf_hs > 0 && k == rf_hs_k + rdd) refill_done = 1'b1;
      if (wb_req_vld) begin
        if (o_wb_vc > 0 && (wb_req_way !== o_wb_way || wb_req_set !== o_wb_set))
          o_wb_unstable = 1;
        o_wb_way = wb_req_way; o_wb_set = wb_req_set; o_wb_vc++;
        if (o_wb_vc > wd) begin
          wb_req_rdy = 1'b1; o_wb_hs++; wb_hs_k = k;
          if (early_wbdone) begin wb_done = 1'b1; wbdone_given = 1; end
        end
      end
      if (!early_wbdone && o_wb_hs > 0 && k == wb_hs_k + wdd) begin
        wb_done = 1'b1; wbdone_given = 1;
      end
      if (line_wr_en) begin
        o_wr_cnt++; o_wr_k = k; o_wr_set = line_wr_set; o_wr_way = line_wr_way;
        o_wr_tag = line_wr_tag;
      end
      if (miss_resp_vld) begin
        o_resp_cnt++; o_resp_k = k; o_resp_way = miss_resp_way; stop = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_req_vld = 1'b0; miss_req_set = '0; miss_req_tag = '0;
    meta_rd_vld_vec = '0; meta_rd_dirty_vec = '0; plru_rd_way = '0;
    wb_req_rdy = 1'b0; refill_req_rdy = 1'b0; wb_done = 1'b0; refill_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (miss_req_rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", miss_req_rdy);
    else n_pass++;
    n_checks++;
    if ({meta_rd_en, plru_rd_en, wb_req_vld, refill_req_vld, line_wr_en, miss_resp_vld} !== 6'b0)
      $display("FAIL reset_strobes got %b want 000000",
               {meta_rd_en, plru_rd_en, wb_req_vld, refill_req_vld, line_wr_en, miss_resp_vld});
    else n_pass++;
    n_checks++;
    if ({line_wr_set, line_wr_way, line_wr_tag} !== 27'd0)
      $display("FAIL reset_regs got %h want 0", {line_wr_set, line_wr_way, line_wr_tag});
    else n_pass++;
  endtask

  task automatic test_min_latency();
    run_miss(5'd5, 20'hABCDE, 4'b1011, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             0, 1, 0, 1, 0, 0, 0, 40);
    n_checks++;
    if (o_plru_cnt !== 0) $display("FAIL min_plru got %0d want 0", o_plru_cnt); else n_pass++;
    n_checks++;
    if (o_meta_set !== 5'd5) $display("FAIL min_meta_set got %0d want 5", o_meta_set); else n_pass++;
    n_checks++;
    if (o_wr_way !== 2'd2) $display("FAIL min_wr_way got %0d want 2", o_wr_way); else n_pass++;
    n_checks++;
    if (o_wr_k !== 5) $display("FAIL min_wr_cycle got %0d want 5", o_wr_k); else n_pass++;
    n_checks++;
    if (o_resp_k !== 6) $display("FAIL min_resp_cycle got %0d want 6", o_resp_k); else n_pass++;
    n_checks++;
    if (o_wb_hs !== 0) $display("FAIL min_wb got %0d want 0", o_wb_hs); else n_pass++;
  endtask

  task automatic test_plru_clean();
    run_miss(5'd3, 20'h12345, 4'b1111, 4'b0000, 2'd1, 0, 1, 0, 1, 0, 0, 0, 40);
    n_checks++;
    if (o_plru_cnt !== 1) $display("FAIL plru_cnt got %0d want 1", o_plru_cnt); else n_pass++;
    n_checks++;
    if (o_plru_set !== 5'd3) $display("FAIL plru_set got %0d want 3", o_plru_set); else n_pass++;
    n_checks++;
    if (o_wb_vc !== 0) $display("FAIL plru_wb_vld got %0d want 0", o_wb_vc); else n_pass++;
    n_checks++;
    if (o_wr_way !== 2'd1 || o_resp_way !== 2'd1)
      $display("FAIL plru_way got wr=%0d resp=%0d want 1", o_wr_way, o_resp_way);
    else n_pass++;
  endtask

  task automatic test_dirty_wb();
    run_miss(5'd9, 20'h0F0F0, 4'b1111, 4'b0100, 2'd2, 3, 2, 1, 2, 0, 0, 0, 60);
    n_checks++;
    if (o_wb_hs !== 1 || o_wb_way !== 2'd2 || o_wb_set !== 5'd9)
      $display("FAIL wb_req got hs=%0d way=%0d set=%0d want 1/2/9", o_wb_hs, o_wb_way, o_wb_set);
    else n_pass++;
    n_checks++;
    if (o_wb_vc !== 4 || o_wb_unstable)
      $display("FAIL wb_hold got cycles=%0d unstable=%0d want 4/0", o_wb_vc, o_wb_unstable);
    else n_pass++;
    n_checks++;
    if (o_rf_early || o_rf_hs !== 1)
      $display("FAIL wb_order got early=%0d rf_hs=%0d want 0/1", o_rf_early, o_rf_hs);
    else n_pass++;
    n_checks++;
    if (o_resp_k !== model_resp_k(1, 3, 2, 1, 2))
      $display("FAIL wb_resp_cycle got %0d want %0d", o_resp_k, model_resp_k(1, 3, 2, 1, 2));
    else n_pass++;
  endtask

  task automatic test_early_wbdone();
    run_miss(5'd17, 20'h55555, 4'b1111, 4'b0001, 2'd0, 1, 1, 0, 1, 1, 0, 0, 30);
    n_checks++;
    if (o_wb_hs !== 1) $display("FAIL early_wb_hs got %0d want 1", o_wb_hs); else n_pass++;
    n_checks++;
    if (o_rf_hs !== 0 || o_resp_cnt !== 0 || o_wr_cnt !== 0)
      $display("FAIL early_wbdone got rf=%0d wr=%0d resp=%0d want 0/0/0",
               o_rf_hs, o_wr_cnt, o_resp_cnt);
    else n_pass++;
    n_checks++;
    if (o_rdy_hi !== 0) $display("FAIL early_rdy got %0d want 0", o_rdy_hi); else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    run_miss(5'd21, 20'hC0FFE, 4'b0111, 4'b0000, 2'd0, 0, 1, 0, 1000, 0, 5, 0, 14);
    n_checks++;
    if (o_rdy_after_rst !== 1'b1)
      $display("FAIL rstmid_rdy got %b want 1", o_rdy_after_rst);
    else n_pass++;
    n_checks++;
    if (o_wr_cnt !== 0 || o_resp_cnt !== 0)
      $display("FAIL rstmid_ignored got wr=%0d resp=%0d want 0/0", o_wr_cnt, o_resp_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_miss(5'd1, 20'h11111, 4'b1110, 4'b0000, 2'd3, 0, 1, 1, 1, 0, 0, 1, 40);
    n_checks++;
    if (o_rdy_hi !== 0 || o_meta_cnt !== 1)
      $display("FAIL b2b_first got rdy_hi=%0d meta=%0d want 0/1", o_rdy_hi, o_meta_cnt);
    else n_pass++;
    n_checks++;
    if (o_resp_k !== model_resp_k(0, 0, 1, 1, 1) || o_resp_way !== 2'd0)
      $display("FAIL b2b_first_resp got k=%0d way=%0d want %0d/0",
               o_resp_k, o_resp_way, model_resp_k(0, 0, 1, 1, 1));
    else n_pass++;
    run_miss(5'd2, 20'h22222, 4'b1111, 4'b0000, 2'd3, 0, 1, 0, 1, 0, 0, 0, 40);
    n_checks++;
    if (o_start_rdy !== 1'b1) $display("FAIL b2b_second_rdy got %b want 1", o_start_rdy);
    else n_pass++;
    n_checks++;
    if (o_wr_tag !== 20'h22222 || o_wr_set !== 5'd2 || o_resp_way !== 2'd3)
      $display("FAIL b2b_second got tag=%h set=%0d way=%0d want 22222/2/3",
               o_wr_tag, o_wr_set, o_resp_way);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0]  s;
    logic [19:0] t;
    logic [3:0]  vv, dv;
    logic [1:0]  pw, ew;
    int          wd, wdd, rd, rdd, ek;
    bit          ed;
    for (int it = 0; it < 25; it++) begin
      s = 5'($urandom); t = 20'($urandom); dv = 4'($urandom); pw = 2'($urandom);
      vv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      wd = $urandom_range(0, 3); wdd = $urandom_range(1, 3);
      rd = $urandom_range(0, 3); rdd = $urandom_range(1, 4);
      ew = model_way(vv, pw);
      ed = model_dirty(vv, dv, pw);
      ek = model_resp_k(ed, wd, wdd, rd, rdd);
      run_miss(s, t, vv, dv, pw, wd, wdd, rd, rdd, 0, 0, 0, 60);
      n_checks++;
      if (o_resp_k !== ek) $display("FAIL rand%0d resp_cycle got %0d want %0d", it, o_resp_k, ek);
      else n_pass++;
      n_checks++;
      if (o_resp_way !== ew || o_wr_way !== ew)
        $display("FAIL rand%0d way got resp=%0d wr=%0d want %0d", it, o_resp_way, o_wr_way, ew);
      else n_pass++;
      n_checks++;
      if (o_wr_tag !== t || o_wr_set !== s || o_rf_tag !== t || o_rf_set !== s)
        $display("FAIL rand%0d install got tag=%h set=%0d want %h/%0d", it, o_wr_tag, o_wr_set, t, s);
      else n_pass++;
      n_checks++;
      if (o_plru_cnt !== ((vv == 4'hF) ? 1 : 0))
        $display("FAIL rand%0d plru_cnt got %0d want %0d", it, o_plru_cnt, (vv == 4'hF) ? 1 : 0);
      else n_pass++;
      n_checks++;
      if (o_wb_hs !== (ed ? 1 : 0) || (ed && o_wb_way !== ew) || o_rf_early)
        $display("FAIL rand%0d wb got hs=%0d way=%0d early=%0d want %0d/%0d/0",
                 it, o_wb_hs, o_wb_way, o_rf_early, ed ? 1 : 0, ew);
      else n_pass++;
      n_checks++;
      if (o_rdy_hi !== 0 || o_wr_k !== ek - 1)
        $display("FAIL rand%0d timing got rdy_hi=%0d wr_k=%0d want 0/%0d", it, o_rdy_hi, o_wr_k, ek - 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_plru_clean();
    test_dirty_wb();
    test_early_wbdone();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvh_l1d_miss_victim_ctrl.md
Name: rvh_l1d_miss_victim_ctrl

Overview:
- Per-miss L1D replacement controller. It is the requester side of the L1D PLRU replacement-state interface: it issues the refill-time victim read, which also advances the PLRU state.
- Sequence per accepted miss: read set metadata, choose a victim (first invalid way, else the PLRU way), write back a dirty victim, request the refill, write the new tag/line, respond.
- Sits between the L1D miss queue and the PLRU, metadata array and memory-side request ports.
- Handles one miss at a time.

Parameters:
- entry_num, 32, number of sets.
- entry_idx, $clog2(entry_num), set index width.
- way_num, 4, associativity (power of 2, ≥2).
- way_num_idx, $clog2(way_num), way index width.
- tag_w, 20, tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- miss_req_vld  in  1  miss request valid.
- miss_req_rdy  out  1  accept; high only in IDLE.
- miss_req_set  in  entry_idx  miss set index.
- miss_req_tag  in  tag_w  miss tag.
- meta_rd_en  out  1  metadata read strobe.
- meta_rd_set  out  entry_idx  metadata read set.
- meta_rd_vld_vec  in  way_num  per-way valid; returned 1 cycle after meta_rd_en.
- meta_rd_dirty_vec  in  way_num  per-way dirty; same timing as meta_rd_vld_vec.
- plru_rd_en  out  1  PLRU victim read; also advances that set's PLRU state.
- plru_rd_set  out  entry_idx  PLRU set.
- plru_rd_way  in  way_num_idx  PLRU victim way; combinational, same cycle as plru_rd_en.
- wb_req_vld  out  1  writeback request valid.
- wb_req_rdy  in  1  writeback request ready.
- wb_req_set  out  entry_idx  writeback set.
- wb_req_way  out  way_num_idx  writeback way.
- wb_done  in  1  writeback complete pulse.
- refill_req_vld  out  1  refill request valid.
- refill_req_rdy  in  1  refill request ready.
- refill_req_set  out  entry_idx  refill set.
- refill_req_tag  out  tag_w  refill tag.
- refill_done  in  1  refill data arrived pulse.
- line_wr_en  out  1  tag/valid install strobe (1 cycle).
- line_wr_set  out  entry_idx  install set.
- line_wr_way  out  way_num_idx  install way.
- line_wr_tag  out  tag_w  install tag.
- miss_resp_vld  out  1  miss complete pulse; no ready.
- miss_resp_way  out  way_num_idx  installed way.

Behaviour:
- Reset: rst is synchronous, active-high. State goes to IDLE. All strobes/valids are 0; miss_req_rdy=1 in the first cycle after reset. Latched set/tag/way registers clear to 0.
- Reset mid-operation: the in-flight miss is abandoned. No response is produced. Later wb_done/refill_done pulses are ignored in IDLE.
- IDLE:
  - miss_req_rdy=1.
  - On vld&rdy, latch set and tag, go to META.
- META:
  - meta_rd_en=1, meta_rd_set=latched set.
  - Next state SEL.
- SEL (metadata vectors valid this cycle):
  - If any way is invalid, victim = lowest-index invalid way and plru_rd_en stays 0, so the PLRU is not disturbed.
  - Else plru_rd_en=1 for exactly this cycle with plru_rd_set=latched set; victim = plru_rd_way, latched.
  - Victim dirty = victim valid & dirty. Dirty → WB_REQ, else → RF_REQ.
- WB_REQ:
  - wb_req_vld=1 with stable set/way until wb_req_rdy.
  - On handshake → WB_WAIT.
- WB_WAIT:
  - Wait for wb_done, then → RF_REQ.
  - wb_done is sampled only in this state; a pulse in the WB_REQ handshake cycle is ignored.
- RF_REQ:
  - refill_req_vld=1 with stable set/tag until refill_req_rdy.
  - On handshake → RF_WAIT.
- RF_WAIT: on refill_done → WRITE.
- WRITE: line_wr_en=1 with set/victim way/tag for one cycle → RESP.
- RESP: miss_resp_vld=1 and miss_resp_way=victim for one cycle → IDLE.
- Minimum latency (invalid way, rdy and done asserted immediately): accept at T; line_wr_en at T+5; miss_resp_vld at T+6. A new request can be accepted at T+7.
- Every strobe and valid is a registered-state decode; no output is combinational from another output.
- plru_rd_en asserts at most once per miss.

Decomposition:
- Package rvh_l1d_pkg gets a typedef enum for the states (IDLE, META, SEL, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, WRITE, RESP).
- One sub-module: rvh_l1d_first_zero_sel. It is a parameterised priority encoder returning the lowest-index 0 bit of the valid vector plus a found flag.

Test Plan:
- Set 5, meta_rd_vld_vec=4'b1011 → plru_rd_en never asserts; line_wr_way=2; miss_resp_vld at T+6 with rdy/done tied high.
- Set 3 all valid, plru_rd_way=1, dirty=4'b0000 → plru_rd_en high exactly 1 cycle, set=3; no wb_req_vld; install way 1.
- All valid, plru_rd_way=2, dirty=4'b0100; hold wb_req_rdy low 3 cycles → wb_req_vld held with way=2; refill_req_vld only after wb_done.
- wb_done pulsed in the WB_REQ handshake cycle and never again → FSM stays in WB_WAIT; no refill_req_vld.
- rst asserted in RF_WAIT, then refill_done pulsed → no line_wr_en and no miss_resp_vld; miss_req_rdy=1 the cycle after reset.
- Back-to-back requests with miss_req_vld held high → second accepted only in IDLE after RESP; miss_req_rdy=0 throughout the first miss.
